// File: rtl/accum_wrap_events.sv
// Wrap-event detector for a modulo-M phase accumulator: one-cycle strobe, wrap counter,
// and a small timestamp FIFO read through a valid/ready port with a sticky overflow flag.
module accum_wrap_events #(
  parameter int unsigned M     = 100,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TSW   = 16,
  localparam int unsigned PW   = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PW-1:0]  phase,
  input  logic           phase_vld,
  output logic           strobe,
  output logic [TSW-1:0] wrap_cnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [TSW-1:0] out_ts,
  output logic           ovf,
  input  logic           ovf_clr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

  logic [TSW-1:0]  ts_q;
  logic [PW-1:0]   prev_q;
  logic            primed_q;
  logic            strobe_q;
  logic [TSW-1:0]  wrap_cnt_q;
  logic [TSW-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic wrap, pop, push, drop;

  always_comb begin
    wrap = phase_vld & primed_q & (phase < prev_q);
    pop  = (cnt_q != '0) & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push = wrap & ((cnt_q != FullCnt) | pop);
    drop = wrap & ~push;

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      strobe_q   <= 1'b0;
      wrap_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ts_q     <= ts_q + 1'b1;
      strobe_q <= wrap;
      if (phase_vld) begin
        prev_q   <= phase;
        primed_q <= 1'b1;
      end
      if (wrap) wrap_cnt_q <= wrap_cnt_q + 1'b1;
      if (push) begin
        mem_q[wr_ptr_q] <= ts_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign strobe    = strobe_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign out_valid = (cnt_q != '0);
  assign out_ts    = mem_q[rd_ptr_q];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_accum_wrap_events.sv
// Directed bench for accum_wrap_events: priming, wrap detection, FIFO order,
// overflow, simultaneous push/pop when full, and asynchronous reset mid-burst.
module tb_accum_wrap_events;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  phase;
  logic        phase_vld;
  logic        strobe;
  logic [15:0] wrap_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ts;
  logic        ovf;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  accum_wrap_events #(.M(100), .DEPTH(4), .TSW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .phase_vld (phase_vld),
    .strobe    (strobe),
    .wrap_cnt  (wrap_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ts    (out_ts),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, take an edge, sample 1 time unit later.
  task automatic step(input int ph, input logic v, input logic r, input logic c);
    phase     = 7'(ph);
    phase_vld = v;
    out_ready = r;
    ovf_clr   = c;
    @(posedge clk);
    #1;
  endtask

  // Reset released on a falling edge so the next rising edge sees ts == 0.
  task automatic do_reset();
    phase_vld = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    phase     = '0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_strobe", 32'(strobe), 0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_ts", 32'(out_ts), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // Step 30 sequence: wraps at the samples of 20 (ts 4) and 10 (ts 7)
    step(0, 1, 0, 0);  chk("s30_e0", 32'(strobe), 0);
    step(30, 1, 0, 0); chk("s30_e1", 32'(strobe), 0);
    step(60, 1, 0, 0); chk("s30_e2", 32'(strobe), 0);
    step(90, 1, 0, 0); chk("s30_e3", 32'(strobe), 0);
    step(20, 1, 0, 0); chk("s30_e4", 32'(strobe), 1);
    chk("s30_valid_after_push", 32'(out_valid), 1);
    step(50, 1, 0, 0); chk("s30_e5", 32'(strobe), 0);
    step(80, 1, 0, 0); chk("s30_e6", 32'(strobe), 0);
    step(10, 1, 0, 0); chk("s30_e7", 32'(strobe), 1);
    chk("s30_wrap_cnt", 32'(wrap_cnt), 2);
    chk("s30_head0", 32'(out_ts), 4);
    step(0, 0, 1, 0);
    chk("s30_head1", 32'(out_ts), 7);
    chk("s30_valid1", 32'(out_valid), 1);
    step(0, 0, 1, 0);
    chk("s30_empty", 32'(out_valid), 0);

    // Priming: first sample 5 over prev 0 is not a wrap; 3 then is
    do_reset();
    step(5, 1, 0, 0); chk("prime_no_strobe", 32'(strobe), 0);
    step(3, 1, 0, 0); chk("prime_wrap", 32'(strobe), 1);
    chk("prime_wrap_cnt", 32'(wrap_cnt), 1);

    // Step 0 never wraps; wrap survives a phase_vld gap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(42, 1, 0, 0);
      chk("step0_strobe", 32'(strobe), 0);
    end
    chk("step0_wrap_cnt", 32'(wrap_cnt), 0);
    step(10, 0, 0, 0); chk("gap0_strobe", 32'(strobe), 0);
    step(10, 0, 0, 0); chk("gap1_strobe", 32'(strobe), 0);
    step(10, 1, 0, 0); chk("gap_wrap", 32'(strobe), 1);
    chk("gap_wrap_cnt", 32'(wrap_cnt), 1);

    // Overflow: 5 wraps (ts 1,3,5,7,9) into a depth-4 FIFO, fifth dropped
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(50, 1, 0, 0);
      step(10, 1, 0, 0);
    end
    chk("ovf_valid4", 32'(out_valid), 1);
    chk("ovf_not_yet", 32'(ovf), 0);
    step(50, 1, 0, 0);
    step(10, 1, 0, 0);
    chk("ovf_drop_strobe", 32'(strobe), 1);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_wrap_cnt", 32'(wrap_cnt), 5);
    chk("ovf_head0", 32'(out_ts), 1);
    step(0, 0, 1, 0); chk("ovf_head1", 32'(out_ts), 3);
    step(0, 0, 1, 0); chk("ovf_head2", 32'(out_ts), 5);
    step(0, 0, 1, 0); chk("ovf_head3", 32'(out_ts), 7);
    step(0, 0, 1, 0); chk("ovf_drained", 32'(out_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    step(0, 0, 0, 1); chk("ovf_cleared", 32'(ovf), 0);

    // Full FIFO with pop and push on the same edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(50, 1, 0, 0);
      step(10, 1, 0, 0);
    end
    step(50, 1, 0, 0);
    step(10, 1, 1, 0);
    chk("full_pp_strobe", 32'(strobe), 1);
    chk("full_pp_ovf", 32'(ovf), 0);
    chk("full_pp_head", 32'(out_ts), 3);
    step(0, 0, 1, 0); chk("full_pp_h5", 32'(out_ts), 5);
    step(0, 0, 1, 0); chk("full_pp_h7", 32'(out_ts), 7);
    step(0, 0, 1, 0); chk("full_pp_h9", 32'(out_ts), 9);
    chk("full_pp_valid", 32'(out_valid), 1);
    step(0, 0, 1, 0); chk("full_pp_empty", 32'(out_valid), 0);

    // Asynchronous reset with 3 entries queued, just after a wrap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(50, 1, 0, 0);
      step(10, 1, 0, 0);
    end
    chk("mid_pre_cnt", 32'(wrap_cnt), 3);
    chk("mid_pre_strobe", 32'(strobe), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_wrap_cnt", 32'(wrap_cnt), 0);
    chk("mid_ovf", 32'(ovf), 0);
    chk("mid_strobe", 32'(strobe), 0);
    @(negedge clk);
    rst = 1'b0;
    step(5, 1, 0, 0); chk("mid_reprime", 32'(strobe), 0);
    chk("mid_reprime_cnt", 32'(wrap_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
